// File: rtl/crc32_stream_scheduler.sv
// crc32_stream_scheduler: round-robin sharing of one CRC32 engine among N_REQ word-stream requesters.
// Optional DRAIN watchdog enabled by defining CRC_SCHED_TIMEOUT_EN.
module crc32_stream_scheduler #(
   parameter int N_REQ          = 4,
   parameter int ID_W           = 2,
   parameter int ENG_LATENCY    = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [N_REQ*32-1:0]   req_data,
   input  logic [N_REQ-1:0]      req_last,
   output logic [N_REQ-1:0]      req_ready,
   output logic                  eng_enable,
   output logic                  eng_sop,
   output logic [31:0]           eng_data,
   input  logic [31:0]           eng_crc,
   input  logic                  eng_valid,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [ID_W-1:0]       res_id,
   output logic [31:0]           res_crc,
   output logic                  res_err,
   output logic                  busy
);
   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, RESULT} state_t;
   state_t state_q, state_d;
   logic [ID_W-1:0] ptr_q, ptr_d, grant_q, grant_d, res_id_q, res_id_d, pick;
   logic first_q, first_d, eng_enable_q, eng_enable_d, eng_sop_q, eng_sop_d, res_err_q, res_err_d;
   logic [31:0] eng_data_q, eng_data_d, res_crc_q, res_crc_d, cur_data;
   logic [7:0] lat_q, lat_d;
   logic found, accept, cur_last, lat_ok, tmo_exp;
`ifdef CRC_SCHED_TIMEOUT_EN
   logic [15:0] tmo_q, tmo_d;
   assign tmo_exp = tmo_q == 16'(TIMEOUT_CYCLES - 1);
`else
   assign tmo_exp = 1'b0;
`endif
   assign cur_data  = req_data[int'(grant_q)*32 +: 32];
   assign cur_last  = req_last[grant_q];
   assign accept    = (state_q == STREAM) && req_valid[grant_q];
   assign lat_ok    = lat_q >= 8'(ENG_LATENCY);
   assign req_ready = (state_q == STREAM) ? (N_REQ'(1) << grant_q) : '0;
   assign eng_enable = eng_enable_q;
   assign eng_sop    = eng_sop_q;
   assign eng_data   = eng_data_q;
   assign res_valid  = state_q == RESULT;
   assign res_id     = res_id_q;
   assign res_crc    = res_crc_q;
   assign res_err    = res_err_q;
   assign busy       = state_q != IDLE;
   // first valid requester at or after the round-robin pointer, wrapping
   always_comb begin
      pick  = ptr_q;
      found = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && req_valid[(int'(ptr_q) + i) % N_REQ]) begin
            pick  = ID_W'((int'(ptr_q) + i) % N_REQ);
            found = 1'b1;
         end
      end
   end
   // next-state and datapath: grant, stream words, wait engine latency, hold result
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      grant_d      = grant_q;
      first_d      = first_q;
      eng_enable_d = 1'b0;
      eng_sop_d    = 1'b0;
      eng_data_d   = eng_data_q;
      lat_d        = lat_q;
      res_id_d     = res_id_q;
      res_crc_d    = res_crc_q;
      res_err_d    = res_err_q;
`ifdef CRC_SCHED_TIMEOUT_EN
      tmo_d        = tmo_q;
`endif
      case (state_q)
         IDLE: if (found) begin
            grant_d = pick;
            first_d = 1'b1;
            state_d = STREAM;
         end
         STREAM: if (accept) begin
            eng_enable_d = 1'b1;
            eng_sop_d    = first_q;
            eng_data_d   = cur_data;
            first_d      = 1'b0;
            if (cur_last) begin
               state_d = DRAIN;
               lat_d   = '0;
`ifdef CRC_SCHED_TIMEOUT_EN
               tmo_d   = '0;
`endif
            end
         end
         DRAIN: begin
            lat_d = lat_ok ? lat_q : lat_q + 8'd1;
`ifdef CRC_SCHED_TIMEOUT_EN
            tmo_d = tmo_q + 16'd1;
`endif
            if (lat_ok && eng_valid) begin
               res_crc_d = eng_crc;
               res_id_d  = grant_q;
               res_err_d = 1'b0;
               state_d   = RESULT;
            end else if (tmo_exp) begin
               res_crc_d = 32'hFFFF_FFFF;
               res_id_d  = grant_q;
               res_err_d = 1'b1;
               state_d   = RESULT;
            end
         end
         default: if (res_ready) begin
            ptr_d   = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
            state_d = IDLE;
         end
      endcase
   end
   // state register; reset drops any in-flight frame
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         grant_q      <= '0;
         first_q      <= 1'b0;
         eng_enable_q <= 1'b0;
         eng_sop_q    <= 1'b0;
         eng_data_q   <= '0;
         lat_q        <= '0;
         res_id_q     <= '0;
         res_crc_q    <= '0;
         res_err_q    <= 1'b0;
`ifdef CRC_SCHED_TIMEOUT_EN
         tmo_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         grant_q      <= grant_d;
         first_q      <= first_d;
         eng_enable_q <= eng_enable_d;
         eng_sop_q    <= eng_sop_d;
         eng_data_q   <= eng_data_d;
         lat_q        <= lat_d;
         res_id_q     <= res_id_d;
         res_crc_q    <= res_crc_d;
         res_err_q    <= res_err_d;
`ifdef CRC_SCHED_TIMEOUT_EN
         tmo_q        <= tmo_d;
`endif
      end
   end
endmodule

// File: tb/tb_crc32_stream_scheduler.sv
// tb_crc32_stream_scheduler: table-driven frames plus corner sequences, scoreboard on results.
module tb_crc32_stream_scheduler;
   localparam int N = 4;
   localparam logic [31:0] SEED = 32'hCDBEDC53;
   logic clk = 1'b0, reset;
   logic [N-1:0] req_valid, req_last, req_ready;
   logic [N*32-1:0] req_data;
   logic eng_enable, eng_sop, eng_valid, res_valid, res_ready, res_err, busy;
   logic [31:0] eng_data, eng_crc, res_crc;
   logic [1:0] res_id;
   logic tb_valid [N];
   logic tb_last [N];
   logic [31:0] tb_data [N];
   typedef struct { logic [1:0] id; logic [31:0] crc; logic err; } exp_t;
   typedef struct { int id; int n; logic [3:0][31:0] w; int gap; logic [31:0] crc; } vec_t;
   exp_t sb [$];
   logic [33:0] trace [$];
   logic trace_on, mute;
   int errs = 0, checks = 0, cyc = 0, t_en = 0, last_lat = 0;
   int t_res [N];
   int t_rdy [N];
   logic [31:0] acc;
   logic [1:0] vp;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         req_valid[i] = tb_valid[i];
         req_last[i]  = tb_last[i];
         req_data[32*i +: 32] = tb_data[i];
      end
   end

   crc32_stream_scheduler #(.N_REQ(N), .ID_W(2), .ENG_LATENCY(2), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
      .req_ready(req_ready), .eng_enable(eng_enable), .eng_sop(eng_sop), .eng_data(eng_data),
      .eng_crc(eng_crc), .eng_valid(eng_valid), .res_valid(res_valid), .res_ready(res_ready),
      .res_id(res_id), .res_crc(res_crc), .res_err(res_err), .busy(busy));

   // engine stub: rotate-xor accumulator, valid two cycles after each enable
   always_ff @(posedge clk) begin
      if (reset) begin
         acc <= '0;
         vp  <= '0;
      end else begin
         if (eng_enable) acc <= eng_sop ? (SEED ^ eng_data) : ({acc[30:0], acc[31]} ^ eng_data);
         vp <= {vp[0], eng_enable & ~mute};
      end
   end
   assign eng_crc   = acc;
   assign eng_valid = vp[1];

   function automatic logic [31:0] model(input logic [3:0][31:0] w, input int n);
      logic [31:0] a;
      a = SEED ^ w[0];
      for (int i = 1; i < n; i++) a = {a[30:0], a[31]} ^ w[i];
      return a;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // result monitor and scoreboard
   always @(negedge clk) begin
      if (eng_enable) t_en = cyc;
      if (trace_on) trace.push_back({eng_enable, eng_sop, eng_data});
      if (!reset && res_valid && res_ready) begin
         t_res[res_id] = cyc;
         last_lat = cyc - t_en;
         if (sb.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL unexpected_result id=%0d crc=%h", res_id, res_crc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("res_id", 32'(res_id), 32'(e.id));
            chk("res_crc", res_crc, e.crc);
            chk("res_err", 32'(res_err), 32'(e.err));
         end
      end
   end

   task automatic push(input int id, input logic [31:0] crc, input logic err);
      exp_t e;
      e.id = 2'(id);
      e.crc = crc;
      e.err = err;
      sb.push_back(e);
   endtask

   task automatic send(input int id, input int n, input logic [3:0][31:0] w, input int gap);
      for (int k = 0; k < n; k++) begin
         logic ok;
         ok = 1'b0;
         tb_data[id]  = w[k];
         tb_last[id]  = (k == n - 1);
         tb_valid[id] = 1'b1;
         for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk);
            if (req_ready[id]) begin
               ok = 1'b1;
               if (t_rdy[id] == 0) t_rdy[id] = cyc;
            end
            @(posedge clk);
            #1;
         end
         chk("word_accepted", 32'(ok), 32'd1);
         tb_valid[id] = 1'b0;
         tb_last[id]  = 1'b0;
         if (k < n - 1) repeat (gap) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic wait_idle(input int budget);
      logic done;
      done = 1'b0;
      for (int c = 0; c < budget && !done; c++) begin
         @(negedge clk);
         if (!busy && sb.size() == 0) done = 1'b1;
      end
      chk("idle_reached", 32'(done), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      for (int i = 0; i < N; i++) tb_valid[i] = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      sb.delete();
   endtask

   initial begin
      vec_t tbl [5];
      logic [3:0][31:0] w1;
      int k;
      logic seen;
      for (int i = 0; i < N; i++) begin
         tb_valid[i] = 1'b0;
         tb_last[i]  = 1'b0;
         tb_data[i]  = '0;
         t_res[i] = 0;
         t_rdy[i] = 0;
      end
      res_ready = 1'b1;
      mute = 1'b0;
      trace_on = 1'b0;
      tbl[0] = '{0, 1, {32'h0, 32'h0, 32'h0, 32'h12345678}, 0, 32'hDF8A8A2B};
      tbl[1] = '{3, 2, {32'h0, 32'h0, 32'h00000001, 32'hDEADBEEF}, 0, 32'h0};
      tbl[2] = '{2, 3, {32'h0, 32'hCAFEF00D, 32'hA5A5A5A5, 32'h13579BDF}, 1, 32'h0};
      tbl[3] = '{1, 4, {32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32'h00000001}, 0, 32'h0};
      tbl[4] = '{3, 1, {32'h0, 32'h0, 32'h0, 32'hFFFFFFFF}, 0, 32'h0};
      for (int i = 1; i < 5; i++) tbl[i].crc = model(tbl[i].w, tbl[i].n);

      reset = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_eng", {29'd0, eng_enable, eng_sop, busy}, 32'd0);
      chk("rst_eng_data", eng_data, 32'd0);
      chk("rst_res", {27'd0, res_valid, res_id, res_err}, 32'd0);
      chk("rst_res_crc", res_crc, 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      for (int i = 0; i < 5; i++) begin
         push(tbl[i].id, tbl[i].crc, 1'b0);
         send(tbl[i].id, tbl[i].n, tbl[i].w, tbl[i].gap);
         wait_idle(200);
         if (i == 0) chk("t1_drain_latency", 32'(last_lat), 32'd3);
      end

      trace.delete();
      trace_on = 1'b1;
      w1 = {32'h0, 32'h0, 32'h9ABCDEF0, 32'h12345678};
      push(0, model(w1, 2), 1'b0);
      send(0, 2, w1, 2);
      wait_idle(200);
      trace_on = 1'b0;
      k = -1;
      for (int i = 0; i < trace.size(); i++) if (k < 0 && trace[i][33]) k = i;
      if (k < 0 || k + 4 > trace.size()) k = 0;
      chk("t3_en_sop_0", 32'(trace[k][33:32]), 32'd3);
      chk("t3_en_sop_1", 32'(trace[k+1][33:32]), 32'd0);
      chk("t3_en_sop_2", 32'(trace[k+2][33:32]), 32'd0);
      chk("t3_en_sop_3", 32'(trace[k+3][33:32]), 32'd2);
      chk("t3_data_hold", trace[k+2][31:0], 32'h12345678);
      chk("t3_data_last", trace[k+3][31:0], 32'h9ABCDEF0);

      do_reset();
      for (int i = 0; i < N; i++) begin
         t_rdy[i] = 0;
         t_res[i] = 0;
      end
      w1 = {32'h0, 32'h0, 32'h00C0FFEE, 32'h11111111};
      push(1, model(w1, 2), 1'b0);
      push(2, model(w1, 1), 1'b0);
      fork
         send(1, 2, w1, 0);
         send(2, 1, w1, 0);
      join
      wait_idle(200);
      chk("t2_ch1_before_ch2", 32'(t_res[1] != 0 && t_res[1] < t_rdy[2]), 32'd1);
      push(0, model(w1, 1), 1'b0);
      send(0, 1, w1, 0);
      wait_idle(200);
      push(3, model(w1, 2), 1'b0);
      push(0, model(w1, 1), 1'b0);
      fork
         send(0, 1, w1, 0);
         send(3, 2, w1, 0);
      join
      wait_idle(300);

      do_reset();
      res_ready = 1'b0;
      w1 = {32'h0, 32'h0, 32'h0, 32'h5A5A0F0F};
      push(0, model(w1, 1), 1'b0);
      push(1, model(w1, 1), 1'b0);
      fork
         send(0, 1, w1, 0);
         send(1, 1, w1, 0);
      join_none
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge clk);
         if (res_valid) seen = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      chk("t4_res_valid_seen", 32'(seen), 32'd1);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         chk("t4_hold_valid_id", {29'd0, res_valid, res_id}, 32'd4);
         chk("t4_hold_crc", res_crc, model(w1, 1));
         chk("t4_no_ready", 32'(req_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      res_ready = 1'b1;
      wait fork;
      wait_idle(200);

      do_reset();
      tb_data[0] = 32'hAAAA0001;
      tb_last[0] = 1'b0;
      tb_valid[0] = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
         @(negedge clk);
         seen = req_ready[0];
         @(posedge clk);
         #1;
      end
      chk("t5_first_accept", 32'(seen), 32'd1);
      tb_valid[0] = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("t5_rst_eng", {29'd0, eng_enable, eng_sop, busy}, 32'd0);
      chk("t5_rst_data", eng_data, 32'd0);
      chk("t5_rst_res", {27'd0, res_valid, res_id, res_err}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      w1 = {32'h0, 32'h0, 32'h0, 32'h12345678};
      push(0, 32'hDF8A8A2B, 1'b0);
      send(0, 1, w1, 0);
      wait_idle(200);

      do_reset();
      mute = 1'b1;
`ifdef CRC_SCHED_TIMEOUT_EN
      push(2, 32'hFFFFFFFF, 1'b1);
      send(2, 1, w1, 0);
      wait_idle(200);
      chk("t6_timeout_latency", 32'(last_lat), 32'd16);
`else
      send(2, 1, w1, 0);
      repeat (100) @(posedge clk);
      #1;
      @(negedge clk);
      chk("t6_busy_stuck", {30'd0, busy, res_valid}, 32'd2);
`endif
      mute = 1'b0;
      do_reset();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
